// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the data-cache write-side logic.
package dcache_pkg;

  localparam int DCACHE_ADDR_WIDTH = 9;
  localparam int DCACHE_DATA_WIDTH = 32;
  localparam int DCACHE_LINE_WORDS = 8;
  localparam int DCACHE_BE_WIDTH   = DCACHE_DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } fill_state_e;

  // One SRAM write-port cycle.
  typedef struct packed {
    logic                         en;
    logic [DCACHE_ADDR_WIDTH-1:0] addr;
    logic [DCACHE_DATA_WIDTH-1:0] data;
    logic [DCACHE_BE_WIDTH-1:0]   be;
  } wr_port_t;

endpackage

// File: rtl/dcache_fill_writer_if.sv
// Request, store and SRAM write-port signals of the fill writer.
// master = requester side (refill path / LSU / SRAM observer), slave = writer.
interface dcache_fill_writer_if
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int LINE_WORDS = DCACHE_LINE_WORDS
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int LW_BITS  = $clog2(LINE_WORDS);

  logic                         fill_req_valid;
  logic                         fill_req_ready;
  logic [ADDR_WIDTH-LW_BITS-1:0] fill_req_index;
  logic                         fill_beat_valid;
  logic                         fill_beat_ready;
  logic [DATA_WIDTH-1:0]        fill_beat_data;
  logic                         st_valid;
  logic                         st_ready;
  logic [ADDR_WIDTH-1:0]        st_addr;
  logic [DATA_WIDTH-1:0]        st_data;
  logic [BE_WIDTH-1:0]          st_be;
  logic                         sram_wr_en;
  logic [ADDR_WIDTH-1:0]        sram_wr_addr;
  logic [DATA_WIDTH-1:0]        sram_wr_data;
  logic [BE_WIDTH-1:0]          sram_wr_byte_en;
  logic                         fill_done;
  logic                         fill_err;
  logic                         busy;

  modport master (
    output fill_req_valid, fill_req_index, fill_beat_valid, fill_beat_data,
           st_valid, st_addr, st_data, st_be,
    input  fill_req_ready, fill_beat_ready, st_ready,
           sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en,
           fill_done, fill_err, busy
  );

  modport slave (
    input  fill_req_valid, fill_req_index, fill_beat_valid, fill_beat_data,
           st_valid, st_addr, st_data, st_be,
    output fill_req_ready, fill_beat_ready, st_ready,
           sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en,
           fill_done, fill_err, busy
  );

endinterface

// File: rtl/dcache_wr_port_reg.sv
// Registered SRAM write-port stage: selects the fill or store write and
// presents it one cycle after acceptance. Address/data/byte-enables hold
// their last values while no write is issued.
module dcache_wr_port_reg
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int BE_WIDTH   = DCACHE_BE_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  fill_fire,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  st_fire,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [BE_WIDTH-1:0]   st_be,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [BE_WIDTH-1:0]   wr_be
);

  logic                  wr_en_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [DATA_WIDTH-1:0] wr_data_p1;
  logic [BE_WIDTH-1:0]   wr_be_p1;

  // Stage p1: capture the accepted item; fill wins if both ever coincide.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      wr_be_p1   <= '0;
    end else begin
      wr_en_p1 <= fill_fire | st_fire;
      if (fill_fire) begin
        wr_addr_p1 <= fill_addr;
        wr_data_p1 <= fill_data;
        wr_be_p1   <= '1;
      end else if (st_fire) begin
        wr_addr_p1 <= st_addr;
        wr_data_p1 <= st_data;
        wr_be_p1   <= st_be;
      end
    end
  end

  assign wr_en   = wr_en_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;
  assign wr_be   = wr_be_p1;

endmodule

// File: rtl/dcache_fill_writer.sv
// Write-side engine for the data-cache SRAM: turns line-fill bursts and
// LSU store merges into registered write-port cycles, aborting a fill when
// the bus goes quiet for TIMEOUT cycles.
module dcache_fill_writer
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = DCACHE_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int LINE_WORDS = DCACHE_LINE_WORDS,
  parameter int TIMEOUT    = 64
) (
  input logic                 wr_clk,
  input logic                 tb_wr_rst,
  dcache_fill_writer_if.slave bus
);

  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int IDX_W   = ADDR_WIDTH - LW_BITS;
  // Wide enough to hold TIMEOUT-1.
  localparam int TO_W    = $clog2(TIMEOUT);

  fill_state_e        state, state_nx;
  logic [IDX_W-1:0]   line_idx;
  logic [LW_BITS-1:0] beat_cnt;
  logic [TO_W-1:0]    idle_cnt;
  logic               fill_done_p1;
  logic               fill_err_p1;

  logic               req_ready_c;
  logic               beat_ready_c;
  logic               st_ready_c;
  logic               req_fire;
  logic               beat_fire;
  logic               st_fire;
  logic               last_beat;
  logic               timeout;

  // State register.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) state <= ST_IDLE;
    else           state <= state_nx;
  end

  // Next state, handshakes and completion decisions; readies are held low in reset.
  always_comb begin
    state_nx     = state;
    req_ready_c  = 1'b0;
    beat_ready_c = 1'b0;
    st_ready_c   = 1'b0;
    req_fire     = 1'b0;
    beat_fire    = 1'b0;
    st_fire      = 1'b0;
    last_beat    = 1'b0;
    timeout      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready_c = !tb_wr_rst;
        st_ready_c  = !tb_wr_rst && !bus.fill_req_valid;
        req_fire    = req_ready_c && bus.fill_req_valid;
        st_fire     = st_ready_c && bus.st_valid;
        if (req_fire) state_nx = ST_FILL;
      end
      ST_FILL: begin
        beat_ready_c = !tb_wr_rst;
        beat_fire    = beat_ready_c && bus.fill_beat_valid;
        if (beat_fire) begin
          if (beat_cnt == LW_BITS'(LINE_WORDS - 1)) begin
            last_beat = 1'b1;
            state_nx  = ST_IDLE;
          end
        end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Line index, beat and idle counters.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      line_idx <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (req_fire) begin
      line_idx <= bus.fill_req_index;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else if (beat_fire) begin
      beat_cnt <= beat_cnt + LW_BITS'(1);
      idle_cnt <= '0;
    end else if (timeout) begin
      idle_cnt <= '0;
    end else if (state == ST_FILL) begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  // Stage p1: completion pulses aligned with the write port.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      fill_done_p1 <= 1'b0;
      fill_err_p1  <= 1'b0;
    end else begin
      fill_done_p1 <= last_beat;
      fill_err_p1  <= timeout;
    end
  end

  dcache_wr_port_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_wr_port (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .fill_fire (beat_fire),
    .fill_addr ({line_idx, beat_cnt}),
    .fill_data (bus.fill_beat_data),
    .st_fire   (st_fire),
    .st_addr   (bus.st_addr),
    .st_data   (bus.st_data),
    .st_be     (bus.st_be),
    .wr_en     (bus.sram_wr_en),
    .wr_addr   (bus.sram_wr_addr),
    .wr_data   (bus.sram_wr_data),
    .wr_be     (bus.sram_wr_byte_en)
  );

  assign bus.fill_req_ready  = req_ready_c;
  assign bus.fill_beat_ready = beat_ready_c;
  assign bus.st_ready        = st_ready_c;
  assign bus.fill_done       = fill_done_p1;
  assign bus.fill_err        = fill_err_p1;
  assign bus.busy            = (state == ST_FILL);

endmodule

// File: tb/tb_dcache_fill_writer.sv
// Directed bench for dcache_fill_writer (TIMEOUT = 4 so stall and abort
// boundaries are reachable in a few cycles).
module tb_dcache_fill_writer;
  import dcache_pkg::*;

  logic wr_clk;
  logic tb_wr_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  dcache_fill_writer_if bus ();

  dcache_fill_writer #(.TIMEOUT(4)) dut (
    .wr_clk    (wr_clk),
    .tb_wr_rst (tb_wr_rst),
    .bus       (bus)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  // Cycle counter.
  always @(posedge wr_clk) cyc <= cyc + 1;

  // Observed activity, refreshed by clear_mon at the start of each test.
  wr_port_t wr_q[$];
  int       wr_cyc_q[$];
  bit       wr_done_q[$];
  int       acc_cyc_q[$];
  int       done_cyc_q[$];
  int       err_cyc_q[$];
  int       st_in_fill;
  wr_port_t mon_w;

  // Monitor: sample the DUT away from the active edge.
  always @(negedge wr_clk) begin
    if (!tb_wr_rst) begin
      if (bus.sram_wr_en) begin
        mon_w.en   = 1'b1;
        mon_w.addr = bus.sram_wr_addr;
        mon_w.data = bus.sram_wr_data;
        mon_w.be   = bus.sram_wr_byte_en;
        wr_q.push_back(mon_w);
        wr_cyc_q.push_back(cyc);
        wr_done_q.push_back(bus.fill_done);
      end
      if ((bus.fill_beat_valid && bus.fill_beat_ready) || (bus.st_valid && bus.st_ready))
        acc_cyc_q.push_back(cyc);
      if (bus.fill_done) done_cyc_q.push_back(cyc);
      if (bus.fill_err)  err_cyc_q.push_back(cyc);
      if (bus.busy && bus.st_ready) st_in_fill++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_q.delete(); wr_cyc_q.delete(); wr_done_q.delete();
    acc_cyc_q.delete(); done_cyc_q.delete(); err_cyc_q.delete();
    st_in_fill = 0;
  endtask

  task automatic send_fill_req(input logic [5:0] idx);
    bit ok = 1'b0;
    bus.fill_req_valid = 1'b1;
    bus.fill_req_index = idx;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge wr_clk);
      ok = bus.fill_req_ready;
      tick();
    end
    bus.fill_req_valid = 1'b0;
    check_val("fill_req_accepted", ok, 1);
  endtask

  task automatic send_beat(input logic [31:0] data, input int gap);
    bit ok = 1'b0;
    repeat (gap) tick();
    bus.fill_beat_valid = 1'b1;
    bus.fill_beat_data  = data;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge wr_clk);
      ok = bus.fill_beat_ready;
      tick();
    end
    bus.fill_beat_valid = 1'b0;
    if (!ok) check_val("beat_accepted", ok, 1);
  endtask

  task automatic send_store(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] be);
    bit ok = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_data  = data;
    bus.st_be    = be;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge wr_clk);
      ok = bus.st_ready;
      tick();
    end
    bus.st_valid = 1'b0;
    if (!ok) check_val("store_accepted", ok, 1);
  endtask

  // Compare n fill writes starting at queue position 0 against a linear line.
  task automatic check_fill_writes(input string tag, input int base, input logic [31:0] d0, input int n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, base + i);
      check_val($sformatf("%s_data%0d", tag, i), wr_q[i].data, d0 + i);
      check_val($sformatf("%s_be%0d", tag, i), wr_q[i].be, 4'hF);
      if (i < acc_cyc_q.size())
        check_val($sformatf("%s_lat%0d", tag, i), wr_cyc_q[i] - acc_cyc_q[i], 1);
    end
  endtask

  logic [31:0] st_d[4]  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [3:0]  st_b[4]  = '{4'hF, 4'h1, 4'h0, 4'h8};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tb_wr_rst = 1'b1;
    bus.fill_req_valid = 1'b0; bus.fill_req_index = '0;
    bus.fill_beat_valid = 1'b0; bus.fill_beat_data = '0;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_be = '0;
    repeat (3) @(posedge wr_clk);
    #1;
    // Reset state, with requests pending to show the readies are forced low.
    bus.fill_req_valid = 1'b1;
    bus.st_valid = 1'b1;
    #1;
    check_val("rst_fill_req_ready", bus.fill_req_ready, 0);
    check_val("rst_st_ready", bus.st_ready, 0);
    check_val("rst_beat_ready", bus.fill_beat_ready, 0);
    check_val("rst_wr_en", bus.sram_wr_en, 0);
    check_val("rst_wr_addr", bus.sram_wr_addr, 0);
    check_val("rst_wr_data", bus.sram_wr_data, 0);
    check_val("rst_wr_be", bus.sram_wr_byte_en, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.fill_done, 0);
    check_val("rst_err", bus.fill_err, 0);
    bus.fill_req_valid = 1'b0;
    bus.st_valid = 1'b0;
    tick();
    tb_wr_rst = 1'b0;
    tick();
    check_val("idle_fill_req_ready", bus.fill_req_ready, 1);
    check_val("idle_st_ready", bus.st_ready, 1);

    // Single fill, no stalls: index 5 -> addresses 40..47.
    clear_mon();
    send_fill_req(6'd5);
    for (int i = 0; i < 8; i++) send_beat(32'hA0 + i, 0);
    tick();
    check_val("fill_busy_after", bus.busy, 0);
    repeat (2) tick();
    check_val("fill_nwr", wr_q.size(), 8);
    check_fill_writes("fill", 40, 32'hA0, 8);
    check_val("fill_ndone", done_cyc_q.size(), 1);
    check_val("fill_done_on_last", wr_done_q[7], 1);
    check_val("fill_done_cyc", done_cyc_q[0], wr_cyc_q[7]);
    check_val("fill_nerr", err_cyc_q.size(), 0);

    // Stalled fill: 3-cycle gaps (idle count reaching TIMEOUT-1) before beats 4 and 7.
    clear_mon();
    send_fill_req(6'd5);
    for (int i = 0; i < 8; i++) send_beat(32'hB0 + i, (i == 4 || i == 7) ? 3 : 0);
    repeat (3) tick();
    check_val("stall_nwr", wr_q.size(), 8);
    check_fill_writes("stall", 40, 32'hB0, 8);
    check_val("stall_nerr", err_cyc_q.size(), 0);
    check_val("stall_ndone", done_cyc_q.size(), 1);
    check_val("stall_done_on_47", wr_done_q[7] && (wr_q[7].addr == 9'd47), 1);

    // Timeout: index 2, three beats then silence.
    clear_mon();
    send_fill_req(6'd2);
    for (int i = 0; i < 3; i++) send_beat(32'hC0 + i, 0);
    repeat (8) tick();
    check_val("to_nwr", wr_q.size(), 3);
    check_fill_writes("to", 16, 32'hC0, 3);
    check_val("to_nerr", err_cyc_q.size(), 1);
    check_val("to_err_cyc", err_cyc_q[0] - acc_cyc_q[2], 5);
    check_val("to_ndone", done_cyc_q.size(), 0);
    check_val("to_req_ready", bus.fill_req_ready, 1);
    check_val("to_busy", bus.busy, 0);

    // Store/fill contention: the fill goes first, the store follows fill_done.
    clear_mon();
    bus.st_valid = 1'b1; bus.st_addr = 9'h1FF; bus.st_data = 32'hDEAD_BEEF; bus.st_be = 4'b0101;
    send_fill_req(6'd1);
    for (int i = 0; i < 8; i++) send_beat(32'hD0 + i, 0);
    send_store(9'h1FF, 32'hDEAD_BEEF, 4'b0101);
    repeat (3) tick();
    check_val("cont_nwr", wr_q.size(), 9);
    check_val("cont_nacc", acc_cyc_q.size(), 9);
    check_fill_writes("cont", 8, 32'hD0, 8);
    check_val("cont_st_in_fill", st_in_fill, 0);
    check_val("cont_st_after_done", acc_cyc_q[8] >= done_cyc_q[0], 1);
    check_val("cont_st_addr", wr_q[8].addr, 9'h1FF);
    check_val("cont_st_data", wr_q[8].data, 32'hDEAD_BEEF);
    check_val("cont_st_be", wr_q[8].be, 4'b0101);
    check_val("cont_st_lat", wr_cyc_q[8] - acc_cyc_q[8], 1);

    // Back-to-back stores, including an all-zero byte enable.
    clear_mon();
    for (int i = 0; i < 4; i++) send_store(9'(i), st_d[i], st_b[i]);
    repeat (3) tick();
    check_val("st_nwr", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      check_val($sformatf("st_addr%0d", i), wr_q[i].addr, i);
      check_val($sformatf("st_data%0d", i), wr_q[i].data, st_d[i]);
      check_val($sformatf("st_be%0d", i), wr_q[i].be, st_b[i]);
      check_val($sformatf("st_cyc%0d", i), wr_cyc_q[i] - wr_cyc_q[0], i);
      check_val($sformatf("st_lat%0d", i), wr_cyc_q[i] - acc_cyc_q[i], 1);
    end

    // Reset mid-fill: asserted while the third beat's write is on the port.
    clear_mon();
    send_fill_req(6'd3);
    for (int i = 0; i < 3; i++) send_beat(32'hF0 + i, 0);
    tb_wr_rst = 1'b1;
    #1;
    check_val("mid_rst_wr_en", bus.sram_wr_en, 0);
    check_val("mid_rst_busy", bus.busy, 0);
    check_val("mid_rst_req_ready", bus.fill_req_ready, 0);
    repeat (2) tick();
    tb_wr_rst = 1'b0;
    repeat (3) tick();
    check_val("mid_rst_nwr", wr_q.size(), 2);
    check_val("mid_rst_ndone", done_cyc_q.size(), 0);
    check_val("mid_rst_nerr", err_cyc_q.size(), 0);
    clear_mon();
    send_fill_req(6'd0);
    for (int i = 0; i < 8; i++) send_beat(32'hE0 + i, 0);
    repeat (3) tick();
    check_val("post_rst_nwr", wr_q.size(), 8);
    check_fill_writes("post_rst", 0, 32'hE0, 8);
    check_val("post_rst_ndone", done_cyc_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
